ama_riscv_mem_arbiter: RTL and testbench
========================================

# ama_riscv_mem_arbiter

Two-requester arbiter sharing one memory port between the core's instruction-fetch channel and data channel. It supports a unified memory or a shared cache below the core. Requests pass through combinationally under round-robin arbitration, with a grant lock that holds a stalled request stable. Read responses from the in-order memory are routed back to the issuing requester through an ID FIFO of outstanding reads.

## Interface
Parameters
- AW, 32, address width (CORE_ADDR_BUS_W)
- DW, 32, data width (CORE_DATA_BUS)
- MAX_OUT, 4, maximum outstanding reads; ID FIFO depth, power of 2, ≥2

Ports (one clock; reset is synchronous and active-high)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  in  1  fetch request valid (always a read)
- imem_req_ready  out  1  fetch request accepted
- imem_req_addr  in  AW  fetch address
- imem_rsp_valid  out  1  fetch data valid
- imem_rsp_ready  in  1  core accepts fetch data
- imem_rsp_data  out  DW  fetch data
- dmem_req_valid  in  1  data request valid
- dmem_req_ready  out  1  data request accepted
- dmem_req_addr  in  AW  data address
- dmem_req_wdata  in  DW  store data
- dmem_req_we  in  4  byte write enables; 0 = load
- dmem_rsp_valid  out  1  load data valid
- dmem_rsp_ready  in  1  core accepts load data
- dmem_rsp_data  out  DW  load data
- mem_req_valid  out  1  request to memory valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  AW  muxed address
- mem_req_wdata  out  DW  muxed store data (0 for fetch)
- mem_req_we  out  4  muxed byte enables (0 for fetch)
- mem_rsp_valid  in  1  memory read data valid
- mem_rsp_ready  out  1  arbiter accepts read data
- mem_rsp_data  in  DW  memory read data
- err_unexp_rsp  out  1  sticky: memory response arrived with no outstanding read

## Operation
- Requester IDs: 0 = imem, 1 = dmem. A request is a read when it is a fetch, or a data request with we==0.
- Arbitration when not locked:
  - If only one requester is valid, it is granted.
  - If both are valid, the ID different from last_grant is granted.
- mem_req_* = granted requester's fields. mem_req_valid = granted valid && !(granted is read && fifo_full).
- {imem,dmem}_req_ready = (grant==id) && mem_req_ready && !(read && fifo_full).
- Lock:
  - If mem_req_valid && !mem_req_ready, next cycle lock=1 and lock_id=grant.
  - While locked, grant=lock_id regardless of the other requester.
  - Lock clears on handshake. Requesters must hold valid and fields stable until ready.
- On each request handshake, last_grant <= grant.
- On a read handshake, grant ID is pushed to the ID FIFO. Stores are fire-and-forget: no push, no response.
- Response routing by FIFO head h:
  - {id}_rsp_valid = mem_rsp_valid && !fifo_empty && h==id
  - rsp_data = mem_rsp_data, broadcast to both requesters
  - mem_rsp_ready = !fifo_empty && {h}_rsp_ready
  - Pop on response handshake.
- Push and pop in the same cycle are allowed, including when the FIFO is full. Count is unchanged.
- fifo_full blocks only read requests; a store may still be granted when full.
- mem_rsp_valid while fifo_empty: mem_rsp_ready=0, err_unexp_rsp <= 1 (sticky until rst).

## Timing
- Reset values:
  - last_grant=1, so imem wins the first contention
  - lock=0, FIFO empty (count 0, pointers 0), err_unexp_rsp=0
  - All valid/ready outputs low while FIFO empty and no input valid
- Zero added latency. Request and response paths are combinational, so a request in cycle N reaches memory in cycle N.
- Throughput is one request and one response per cycle.
- FIFO pointers are log2(MAX_OUT) bits and wrap naturally. Count is log2(MAX_OUT)+1 bits.
- Reset mid-operation flushes the FIFO and lock. Memory must be reset in the same cycle; any stale response after reset sets err_unexp_rsp.

## Test plan
- Both valid every cycle, mem_req_ready=1, all loads (we=0) -> grants alternate 0,1,0,1 starting with imem. Responses return to the correct port in issue order.
- dmem store (addr 0x100, wdata 0xDEADBEEF, we=0xF) with mem_req_ready held 0 for 3 cycles while imem also valid -> grant stays dmem for all 4 cycles, fields stable. After handshake, imem is granted next. No FIFO push.
- MAX_OUT=4 fetches issued, mem_rsp_valid held 0 -> 5th fetch gets imem_req_ready=0, but a dmem store is still granted. The first response frees a slot, and a same-cycle new fetch is accepted with count staying at 4.
- Head is dmem, dmem_rsp_ready=0 for 2 cycles, mem_rsp_valid=1 with 0x1234 -> mem_rsp_ready=0 for 2 cycles, then data delivered. imem_rsp_valid stays 0 throughout.
- mem_rsp_valid=1 with empty FIFO -> mem_rsp_ready=0, err_unexp_rsp rises next cycle and stays 1 until rst.
- rst asserted with 3 reads outstanding and lock set -> next cycle FIFO empty, lock=0, and first contention is granted to imem.

Source files
------------

// File: rtl/ama_riscv_mem_arbiter.sv
// ama_riscv_mem_arbiter
//
// Shares one memory port between the core's instruction-fetch channel (id 0)
// and data channel (id 1). Requests pass through combinationally under
// round-robin arbitration. A grant lock keeps a stalled request on the port
// until it is accepted. Read responses from the in-order memory are steered
// back to their issuer by a FIFO of outstanding read ids.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   imem_req_valid/ready/addr  fetch request (always a read)
//   imem_rsp_valid/ready/data  fetch response
//   dmem_req_valid/ready/addr/wdata/we  data request (we==0 is a load)
//   dmem_rsp_valid/ready/data  load response
//   mem_req_valid/ready/addr/wdata/we   muxed request to memory
//   mem_rsp_valid/ready/data   read data from memory
//   err_unexp_rsp              sticky: response seen with no outstanding read
module ama_riscv_mem_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_req_valid,
  output logic          imem_req_ready,
  input  logic [AW-1:0] imem_req_addr,
  output logic          imem_rsp_valid,
  input  logic          imem_rsp_ready,
  output logic [DW-1:0] imem_rsp_data,
  input  logic          dmem_req_valid,
  output logic          dmem_req_ready,
  input  logic [AW-1:0] dmem_req_addr,
  input  logic [DW-1:0] dmem_req_wdata,
  input  logic [3:0]    dmem_req_we,
  output logic          dmem_rsp_valid,
  input  logic          dmem_rsp_ready,
  output logic [DW-1:0] dmem_rsp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  output logic [3:0]    mem_req_we,
  input  logic          mem_rsp_valid,
  output logic          mem_rsp_ready,
  input  logic [DW-1:0] mem_rsp_data,
  output logic          err_unexp_rsp
);

  localparam int unsigned PW = $clog2(MAX_OUT);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUT);

  typedef enum logic { ID_IMEM = 1'b0, ID_DMEM = 1'b1 } req_id_t;
  typedef enum logic { ARB_FREE = 1'b0, ARB_LOCKED = 1'b1 } arb_state_t;

  arb_state_t state_q, state_d;
  req_id_t    lock_id_q, lock_id_d;
  req_id_t    last_grant_q, last_grant_d;
  req_id_t    grant, head;

  logic [MAX_OUT-1:0] id_fifo_q;
  logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic               err_q;

  logic g_valid, g_read;
  logic fifo_empty, fifo_full, block_read;
  logic req_hs, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign head       = req_id_t'(id_fifo_q[rd_ptr_q]);

  // Response routing by the id at the FIFO head; data is broadcast.
  assign imem_rsp_valid = mem_rsp_valid && !fifo_empty && (head == ID_IMEM);
  assign dmem_rsp_valid = mem_rsp_valid && !fifo_empty && (head == ID_DMEM);
  assign imem_rsp_data  = mem_rsp_data;
  assign dmem_rsp_data  = mem_rsp_data;
  assign mem_rsp_ready  = !fifo_empty &&
                          ((head == ID_DMEM) ? dmem_rsp_ready : imem_rsp_ready);
  assign pop            = mem_rsp_valid && mem_rsp_ready;
  assign err_unexp_rsp  = err_q;

  always_comb begin
    if (last_grant_q == ID_IMEM) grant = ID_DMEM;
    else                         grant = ID_IMEM;
    if (state_q == ARB_LOCKED)                   grant = lock_id_q;
    else if (imem_req_valid && !dmem_req_valid)  grant = ID_IMEM;
    else if (dmem_req_valid && !imem_req_valid)  grant = ID_DMEM;
  end

  assign g_valid = (grant == ID_DMEM) ? dmem_req_valid : imem_req_valid;
  assign g_read  = (grant == ID_IMEM) || (dmem_req_we == 4'b0000);

  // A full FIFO only blocks a read when no slot is freed in the same cycle,
  // so a response pop and a new read push can overlap at full occupancy.
  assign block_read = g_read && fifo_full && !pop;

  assign mem_req_valid = g_valid && !block_read;
  assign mem_req_addr  = (grant == ID_DMEM) ? dmem_req_addr : imem_req_addr;
  assign mem_req_wdata = (grant == ID_DMEM) ? dmem_req_wdata : '0;
  assign mem_req_we    = (grant == ID_DMEM) ? dmem_req_we : '0;

  assign req_hs = mem_req_valid && mem_req_ready;
  assign push   = req_hs && g_read;

  // Ready is qualified by the granted valid so an idle port shows no ready.
  assign imem_req_ready = (grant == ID_IMEM) && req_hs;
  assign dmem_req_ready = (grant == ID_DMEM) && req_hs;

  always_comb begin
    state_d      = state_q;
    lock_id_d    = lock_id_q;
    last_grant_d = last_grant_q;
    if (req_hs) begin
      state_d      = ARB_FREE;
      last_grant_d = grant;
    end else if (mem_req_valid) begin
      state_d   = ARB_LOCKED;
      lock_id_d = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_FREE;
      lock_id_q    <= ID_IMEM;
      last_grant_q <= ID_DMEM;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lock_id_q    <= lock_id_d;
      last_grant_q <= last_grant_d;
      if (push) begin
        id_fifo_q[wr_ptr_q] <= grant;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (mem_rsp_valid && fifo_empty) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ama_riscv_mem_arbiter.sv
module tb_ama_riscv_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MAX_OUT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req_valid, imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid, imem_rsp_ready;
  logic [DW-1:0] imem_rsp_data;
  logic          dmem_req_valid, dmem_req_ready;
  logic [AW-1:0] dmem_req_addr;
  logic [DW-1:0] dmem_req_wdata;
  logic [3:0]    dmem_req_we;
  logic          dmem_rsp_valid, dmem_rsp_ready;
  logic [DW-1:0] dmem_rsp_data;
  logic          mem_req_valid, mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic [3:0]    mem_req_we;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic          err_unexp_rsp;

  always #5 clk = ~clk;

  ama_riscv_mem_arbiter #(.AW(AW), .DW(DW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_req_addr(dmem_req_addr), .dmem_req_wdata(dmem_req_wdata),
    .dmem_req_we(dmem_req_we),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_ready(dmem_rsp_ready),
    .dmem_rsp_data(dmem_rsp_data),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_wdata(mem_req_wdata),
    .mem_req_we(mem_req_we),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_rsp_data(mem_rsp_data),
    .err_unexp_rsp(err_unexp_rsp)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Outstanding reads as seen by the reference memory: data it will return
  // and which requester issued the read, oldest first.
  typedef struct {
    logic [DW-1:0] data;
    logic          owner;
  } pend_t;
  pend_t pend[$];

  // Memory behaviour knobs: 0 random, 1 forced low, 2 forced high/when data,
  // 3 (responses only) drive a response regardless of outstanding reads.
  int mem_rdy_mode = 2;
  int rsp_mode = 1;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return ~a;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b0;
    dmem_req_we    = 4'h0;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    idle_inputs();
    rsp_mode = 2;
    imem_rsp_ready = 1'b1;
    dmem_rsp_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (pend.size() == 0) break;
    end
    check("drain_outstanding", pend.size(), 0);
    rsp_mode = 1;
  endtask

  // Reference memory: drives ready/response a little after each rising edge.
  initial begin
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    forever begin
      @(posedge clk);
      #2;
      case (mem_rdy_mode)
        1:       mem_req_ready = 1'b0;
        2:       mem_req_ready = 1'b1;
        default: mem_req_ready = ($urandom_range(3) != 0);
      endcase
      case (rsp_mode)
        1:       mem_rsp_valid = 1'b0;
        2:       mem_rsp_valid = (pend.size() != 0);
        3:       mem_rsp_valid = 1'b1;
        default: mem_rsp_valid = (pend.size() != 0) && ($urandom_range(1) == 1);
      endcase
      mem_rsp_data = (pend.size() != 0) ? pend[0].data : DW'($urandom);
    end
  end

  // Monitor / scoreboard, sampling on the falling edge.
  always @(negedge clk) begin : monitor
    logic i_hs, d_hs, m_hs, m_pop;
    int   pre_size;
    pend_t e;
    if (rst) begin
      pend.delete();
    end else begin
      i_hs     = imem_req_valid && imem_req_ready;
      d_hs     = dmem_req_valid && dmem_req_ready;
      m_hs     = mem_req_valid && mem_req_ready;
      m_pop    = mem_rsp_valid && mem_rsp_ready;
      pre_size = pend.size();
      if (i_hs || d_hs || m_hs) begin
        check("single_grant", i_hs && d_hs, 0);
        check("mem_hs_matches_requester", m_hs, i_hs || d_hs);
      end
      if (i_hs) begin
        check("imem_fields_on_mem", {mem_req_addr, mem_req_we, mem_req_wdata},
              {imem_req_addr, 4'h0, 32'h0});
        check("read_capacity", (pre_size - (m_pop ? 1 : 0)) < MAX_OUT, 1);
      end
      if (d_hs) begin
        check("dmem_fields_on_mem", {mem_req_addr, mem_req_we, mem_req_wdata},
              {dmem_req_addr, dmem_req_we, dmem_req_wdata});
        if (dmem_req_we == 4'h0)
          check("read_capacity", (pre_size - (m_pop ? 1 : 0)) < MAX_OUT, 1);
      end
      if (!mem_rsp_valid) begin
        check("rsp_idle", {imem_rsp_valid, dmem_rsp_valid}, 2'b00);
      end else if (pend.size() == 0) begin
        check("unexp_rsp_not_accepted", mem_rsp_ready, 0);
        check("unexp_rsp_not_routed", {imem_rsp_valid, dmem_rsp_valid}, 2'b00);
      end else begin
        check("rsp_route", {imem_rsp_valid, dmem_rsp_valid},
              pend[0].owner ? 2'b01 : 2'b10);
        check("rsp_backpressure", mem_rsp_ready,
              pend[0].owner ? dmem_rsp_ready : imem_rsp_ready);
        if (mem_rsp_ready) begin
          check("rsp_data", pend[0].owner ? dmem_rsp_data : imem_rsp_data, pend[0].data);
          void'(pend.pop_front());
        end
      end
      if (m_hs && mem_req_we == 4'h0) begin
        e.data  = mem_word(mem_req_addr);
        e.owner = d_hs;
        pend.push_back(e);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic i_done, d_done;
    rst = 1'b1;
    idle_inputs();
    imem_req_addr  = '0;
    dmem_req_addr  = '0;
    dmem_req_wdata = '0;
    imem_rsp_ready = 1'b0;
    dmem_rsp_ready = 1'b0;
    mem_rdy_mode   = 2;
    rsp_mode       = 1;
    do_reset();

    // Reset state: everything quiet even with memory ready.
    @(negedge clk);
    check("reset_outputs_low",
          {imem_req_ready, dmem_req_ready, mem_req_valid, imem_rsp_valid,
           dmem_rsp_valid, mem_rsp_ready, err_unexp_rsp}, 7'b0);
    tick();

    // Both requesters loading every cycle: grants alternate from imem.
    rsp_mode = 2;
    imem_rsp_ready = 1'b1;
    dmem_rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        imem_req_valid = 1'b1;
        imem_req_addr  = 32'h1000 + 32'(k * 4);
        dmem_req_valid = 1'b1;
        dmem_req_addr  = 32'h2000 + 32'(k * 4);
        dmem_req_we    = 4'h0;
      end
      @(negedge clk);
      check("alt_imem_ready", imem_req_ready, (k % 2) == 0);
      check("alt_dmem_ready", dmem_req_ready, (k % 2) == 1);
      tick();
    end
    wait_drain();

    // Stalled store keeps the grant while imem waits.
    do_reset();
    mem_rdy_mode = 2;
    imem_req_valid = 1'b1;
    imem_req_addr  = 32'h3000;
    @(negedge clk);
    check("lock_first_fetch", imem_req_ready, 1);
    tick();
    imem_req_addr  = 32'h3004;
    dmem_req_valid = 1'b1;
    dmem_req_addr  = 32'h100;
    dmem_req_wdata = 32'hDEADBEEF;
    dmem_req_we    = 4'hF;
    for (int k = 0; k < 4; k++) begin
      mem_rdy_mode = (k == 3) ? 2 : 1;
      @(negedge clk);
      check("lock_dmem_ready", dmem_req_ready, k == 3);
      check("lock_imem_waits", imem_req_ready, 0);
      check("lock_fields", {mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_we},
            {1'b1, 32'h100, 32'hDEADBEEF, 4'hF});
      tick();
    end
    dmem_req_valid = 1'b0;
    dmem_req_we    = 4'h0;
    @(negedge clk);
    check("lock_imem_after", imem_req_ready, 1);
    tick();
    wait_drain();

    // FIFO full: reads blocked, stores pass, pop and push overlap.
    do_reset();
    mem_rdy_mode = 2;
    rsp_mode = 1;
    imem_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      imem_req_valid = 1'b1;
      imem_req_addr  = 32'h4000 + 32'(k * 4);
      @(negedge clk);
      check("full_fill_ready", imem_req_ready, 1);
      tick();
    end
    imem_req_addr = 32'h4010;
    @(negedge clk);
    check("full_fetch_blocked", {imem_req_ready, mem_req_valid}, 2'b00);
    tick();
    dmem_req_valid = 1'b1;
    dmem_req_addr  = 32'h200;
    dmem_req_wdata = $urandom;
    dmem_req_we    = 4'h3;
    @(negedge clk);
    check("full_store_granted", {dmem_req_ready, imem_req_ready}, 2'b10);
    tick();
    dmem_req_valid = 1'b0;
    dmem_req_we    = 4'h0;
    rsp_mode = 2;
    @(negedge clk);
    check("full_pop_push", {imem_rsp_valid, imem_req_ready}, 2'b11);
    tick();
    rsp_mode = 1;
    imem_req_addr = 32'h4014;
    @(negedge clk);
    check("full_count_held", imem_req_ready, 0);
    tick();
    wait_drain();

    // Head is dmem, response back-pressured for two cycles.
    do_reset();
    mem_rdy_mode = 2;
    rsp_mode = 1;
    dmem_req_valid = 1'b1;
    dmem_req_addr  = 32'hFFFF_EDCB;
    dmem_req_we    = 4'h0;
    @(negedge clk);
    check("bp_load_accepted", dmem_req_ready, 1);
    tick();
    dmem_req_valid = 1'b0;
    rsp_mode = 2;
    imem_rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      dmem_rsp_ready = (k == 2);
      @(negedge clk);
      check("bp_mem_rsp_ready", mem_rsp_ready, k == 2);
      check("bp_route", {imem_rsp_valid, dmem_rsp_valid}, 2'b01);
      if (k == 2) check("bp_data", dmem_rsp_data, 32'h0000_1234);
      tick();
    end
    rsp_mode = 1;

    // Unexpected response sets the sticky error.
    do_reset();
    rsp_mode = 3;
    @(negedge clk);
    check("unexp_ready_low", mem_rsp_ready, 0);
    check("unexp_err_not_yet", err_unexp_rsp, 0);
    tick();
    rsp_mode = 1;
    @(negedge clk);
    check("unexp_err_set", err_unexp_rsp, 1);
    repeat (5) tick();
    @(negedge clk);
    check("unexp_err_sticky", err_unexp_rsp, 1);
    do_reset();
    @(negedge clk);
    check("unexp_err_cleared", err_unexp_rsp, 0);
    tick();

    // Reset with reads outstanding and a lock held.
    mem_rdy_mode = 2;
    rsp_mode = 1;
    for (int k = 0; k < 3; k++) begin
      imem_req_valid = 1'b1;
      imem_req_addr  = 32'h6000 + 32'(k * 4);
      @(negedge clk);
      check("rst_fill_ready", imem_req_ready, 1);
      tick();
    end
    imem_req_valid = 1'b0;
    dmem_req_valid = 1'b1;
    dmem_req_addr  = 32'h300;
    dmem_req_wdata = 32'h55AA_55AA;
    dmem_req_we    = 4'hF;
    mem_rdy_mode = 1;
    @(negedge clk);
    check("rst_store_stalled", {mem_req_valid, dmem_req_ready}, 2'b10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    imem_req_valid = 1'b1;
    imem_req_addr  = 32'h5000;
    mem_rdy_mode = 2;
    rsp_mode = 3;
    @(negedge clk);
    check("rst_imem_first", {imem_req_ready, dmem_req_ready}, 2'b10);
    check("rst_fifo_flushed", mem_rsp_ready, 0);
    tick();
    rsp_mode = 1;
    imem_req_valid = 1'b0;
    @(negedge clk);
    check("rst_dmem_next", dmem_req_ready, 1);
    tick();
    wait_drain();

    // Randomized traffic checked by the monitor.
    do_reset();
    mem_rdy_mode = 0;
    rsp_mode = 0;
    i_done = 1'b1;
    d_done = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (!imem_req_valid || i_done) begin
        imem_req_valid = ($urandom_range(2) != 0);
        imem_req_addr  = $urandom;
      end
      if (!dmem_req_valid || d_done) begin
        dmem_req_valid = ($urandom_range(2) != 0);
        dmem_req_addr  = $urandom;
        dmem_req_wdata = $urandom;
        dmem_req_we    = ($urandom_range(1) == 1) ? 4'($urandom_range(15, 1)) : 4'h0;
      end
      imem_rsp_ready = ($urandom_range(3) != 0);
      dmem_rsp_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      i_done = imem_req_valid && imem_req_ready;
      d_done = dmem_req_valid && dmem_req_ready;
      tick();
    end
    mem_rdy_mode = 2;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
